// File: rtl/orb_ram_write_arbiter_if.sv
// Packer-side request bus and RAM write port of the orbital-word write arbiter.
// master = packers/RAM side driving requests, slave = the arbiter.
interface orb_ram_write_arbiter_if #(
  parameter int N  = 3,
  parameter int AW = 11,
  parameter int DW = 12
);
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            clr_ovf;
  logic [N-1:0]    busy;
  logic [N-1:0]    ovf;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data;
  logic [2:0]      grant_id;

  modport master (
    output req, req_addr, req_data, clr_ovf,
    input  busy, ovf, ram_we, ram_addr, ram_data, grant_id
  );

  modport slave (
    input  req, req_addr, req_data, clr_ovf,
    output busy, ovf, ram_we, ram_addr, ram_data, grant_id
  );
endinterface

// File: rtl/orb_ram_write_arbiter.sv
// Round-robin arbiter sharing the orbital-word RAM write port between N packers.
// Each packer owns a one-entry hold slot; the FSM drains slots with a stretched strobe.
module orb_ram_write_slot #(
  parameter int AW = 11,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          grant,
  input  logic          clr_ovf,
  output logic          full,
  output logic          ovf,
  output logic [AW-1:0] slot_addr,
  output logic [DW-1:0] slot_data
);
  logic req_ok, take;

  // Address 0 is reserved, so such requests are silently ignored.
  assign req_ok = req & (addr != '0);
  assign take   = req_ok & (~full | grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      ovf       <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
    end else begin
      if (take) begin
        slot_addr <= addr;
        slot_data <= data;
      end
      full <= take | (full & ~grant);
      if (req_ok & full & ~grant) ovf <= 1'b1;
      else if (clr_ovf)           ovf <= 1'b0;
    end
  end
endmodule

module orb_ram_write_arbiter #(
  parameter int N       = 3,
  parameter int AW      = 11,
  parameter int DW      = 12,
  parameter int WE_LEN  = 4,
  parameter int GAP_LEN = 1
) (
  input logic clk,
  input logic rst,
  orb_ram_write_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t                  state, state_d;
  logic [4:0]              cnt, cnt_d;
  logic                    we_q, we_d;
  logic [IW-1:0]           ptr, sel, cand;
  logic                    sel_vld, load;
  logic [N-1:0]            full, ovf, gnt;
  logic [N-1:0][AW-1:0]    slot_addr;
  logic [N-1:0][DW-1:0]    slot_data;
  logic [AW-1:0]           addr_q;
  logic [DW-1:0]           data_q;
  logic [2:0]              gid_q;

  for (genvar i = 0; i < N; i++) begin : g_slot
    orb_ram_write_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .req      (bus.req[i]),
      .addr     (bus.req_addr[i*AW +: AW]),
      .data     (bus.req_data[i*DW +: DW]),
      .grant    (gnt[i]),
      .clr_ovf  (bus.clr_ovf),
      .full     (full[i]),
      .ovf      (ovf[i]),
      .slot_addr(slot_addr[i]),
      .slot_data(slot_data[i])
    );
  end

  // Scan downwards so the slot nearest after ptr is the last (winning) assignment.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (full[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = we_q;
    load    = 1'b0;
    unique case (state)
      IDLE: if (sel_vld) begin
        load    = 1'b1;
        we_d    = 1'b1;
        cnt_d   = 5'd1;
        state_d = WRITE;
      end
      WRITE: if (cnt == 5'(WE_LEN)) begin
        we_d    = 1'b0;
        cnt_d   = 5'd1;
        state_d = GAP;
      end else begin
        cnt_d = cnt + 5'd1;
      end
      GAP: if (cnt == 5'(GAP_LEN)) state_d = IDLE;
           else                     cnt_d   = cnt + 5'd1;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) gnt[i] = load & (sel == IW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      ptr    <= IW'(N - 1);
      addr_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      we_q  <= we_d;
      if (load) begin
        ptr    <= sel;
        addr_q <= slot_addr[sel];
        data_q <= slot_data[sel];
        gid_q  <= 3'(sel);
      end
    end
  end

  assign bus.busy     = full;
  assign bus.ovf      = ovf;
  assign bus.ram_we   = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;
  assign bus.grant_id = gid_q;
endmodule

// File: tb/tb_orb_ram_write_arbiter.sv
// Directed bench for orb_ram_write_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_orb_ram_write_arbiter;
  localparam int N = 3, AW = 11, DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  orb_ram_write_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  orb_ram_write_arbiter #(.N(N), .AW(AW), .DW(DW), .WE_LEN(4), .GAP_LEN(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]            = 1'b1;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_req();
    bus.req = '0;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    bus.req     = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.clr_ovf = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0; bus.clr_ovf = 1'b0;
    step();
    #1;
    tests++; if (bus.busy !== 3'b000) begin fails++; $display("FAIL reset_busy: got %b want 000", bus.busy); end
    tests++; if (bus.ovf !== 3'b000) begin fails++; $display("FAIL reset_ovf: got %b want 000", bus.ovf); end
    tests++; if (bus.ram_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", bus.ram_we); end
    tests++; if (bus.ram_addr !== 11'h0 || bus.ram_data !== 12'h0 || bus.grant_id !== 3'd0) begin
      fails++; $display("FAIL reset_port: addr %h data %h gid %0d want 0/0/0", bus.ram_addr, bus.ram_data, bus.grant_id);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    drive(0, 11'h005, 12'hABC);
    step(); clear_req();
    tests++; if (bus.busy !== 3'b001) begin fails++; $display("FAIL single_busy: got %b want 001", bus.busy); end
    tests++; if (bus.ram_we !== 1'b0) begin fails++; $display("FAIL single_we_early: got %b want 0", bus.ram_we); end
    for (int c = 2; c <= 5; c++) begin
      step();
      tests++;
      if (bus.ram_we !== 1'b1 || bus.ram_addr !== 11'h005 || bus.ram_data !== 12'hABC || bus.grant_id !== 3'd0) begin
        fails++;
        $display("FAIL single_write c%0d: we %b addr %h data %h gid %0d want 1/005/abc/0",
                 c, bus.ram_we, bus.ram_addr, bus.ram_data, bus.grant_id);
      end
    end
    step();
    tests++; if (bus.ram_we !== 1'b0 || bus.busy !== 3'b000) begin
      fails++; $display("FAIL single_end: we %b busy %b want 0/000", bus.ram_we, bus.busy);
    end
    tests++; if (bus.ram_addr !== 11'h005 || bus.ram_data !== 12'hABC) begin
      fails++; $display("FAIL single_hold: addr %h data %h want 005/abc", bus.ram_addr, bus.ram_data);
    end
  endtask

  task automatic test_all_three();
    logic exp_we;
    int   g;
    apply_reset();
    drive(0, 11'h001, 12'h111);
    drive(1, 11'h002, 12'h222);
    drive(2, 11'h003, 12'h333);
    step(); clear_req();
    tests++; if (bus.busy !== 3'b111) begin fails++; $display("FAIL three_busy: got %b want 111", bus.busy); end
    for (int c = 2; c <= 19; c++) begin
      step();
      exp_we = ((c - 2) % 6) < 4;
      g      = (c - 2) / 6;
      tests++;
      if (bus.ram_we !== exp_we) begin
        fails++; $display("FAIL three_we c%0d: got %b want %b", c, bus.ram_we, exp_we);
      end else if (exp_we && (bus.grant_id !== 3'(g) || bus.ram_addr !== 11'(g + 1) ||
                              bus.ram_data !== 12'((g + 1) * 12'h111))) begin
        fails++; $display("FAIL three_word c%0d: gid %0d addr %h data %h want gid %0d", c,
                          bus.grant_id, bus.ram_addr, bus.ram_data, g);
      end
    end
    tests++; if (bus.ovf !== 3'b000) begin fails++; $display("FAIL three_ovf: got %b want 000", bus.ovf); end
  endtask

  task automatic test_overflow();
    apply_reset();
    drive(0, 11'h010, 12'h100);
    step(); clear_req();                        // 1: grant 0
    step();                                     // 2: write 0 starts
    tests++; if (bus.ram_we !== 1'b1) begin fails++; $display("FAIL ovf_we0: got %b want 1", bus.ram_we); end
    drive(1, 11'h020, 12'h200);
    step();                                     // 3
    tests++; if (bus.busy[1] !== 1'b1) begin fails++; $display("FAIL ovf_busy1: got %b want 1", bus.busy[1]); end
    drive(1, 11'h021, 12'h201);
    step(); clear_req();                        // 4
    tests++; if (bus.ovf !== 3'b010) begin fails++; $display("FAIL ovf_set: got %b want 010", bus.ovf); end
    repeat (4) step();                          // 8: write 1
    tests++; if (bus.ram_we !== 1'b1 || bus.grant_id !== 3'd1 || bus.ram_addr !== 11'h020 || bus.ram_data !== 12'h200) begin
      fails++; $display("FAIL ovf_kept: we %b gid %0d addr %h data %h want 1/1/020/200",
                        bus.ram_we, bus.grant_id, bus.ram_addr, bus.ram_data);
    end
    step(); bus.clr_ovf = 1'b1;                 // 9
    step(); bus.clr_ovf = 1'b0;                 // 10
    tests++; if (bus.ovf !== 3'b000) begin fails++; $display("FAIL ovf_clr: got %b want 000", bus.ovf); end
    drive(1, 11'h030, 12'h300);
    step();                                     // 11
    tests++; if (bus.busy[1] !== 1'b1) begin fails++; $display("FAIL ovf_refill: got %b want 1", bus.busy[1]); end
    drive(1, 11'h031, 12'h301);
    bus.clr_ovf = 1'b1;
    step(); clear_req();                        // 12
    tests++; if (bus.ovf[1] !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b want 1", bus.ovf[1]); end
    step(); bus.clr_ovf = 1'b0;                 // 13 (clr held one more cycle)
    tests++; if (bus.ovf !== 3'b000) begin fails++; $display("FAIL ovf_clr2: got %b want 000", bus.ovf); end
    step();                                     // 14: write 1 again
    tests++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 11'h030 || bus.ram_data !== 12'h300) begin
      fails++; $display("FAIL ovf_old_content: we %b addr %h data %h want 1/030/300",
                        bus.ram_we, bus.ram_addr, bus.ram_data);
    end
  endtask

  task automatic test_addr0_regrant();
    apply_reset();
    drive(2, 11'h000, 12'h777);
    step(); clear_req();                        // 1
    tests++; if (bus.busy !== 3'b000) begin fails++; $display("FAIL addr0_busy: got %b want 000", bus.busy); end
    step();                                     // 2
    tests++; if (bus.ram_we !== 1'b0 || bus.ovf !== 3'b000) begin
      fails++; $display("FAIL addr0_idle: we %b ovf %b want 0/000", bus.ram_we, bus.ovf);
    end
    drive(2, 11'h040, 12'h444);
    step();                                     // 3: slot 2 granted this cycle
    tests++; if (bus.busy !== 3'b100) begin fails++; $display("FAIL regrant_busy: got %b want 100", bus.busy); end
    drive(2, 11'h041, 12'h555);
    step(); clear_req();                        // 4
    tests++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 11'h040 || bus.ram_data !== 12'h444 || bus.busy !== 3'b100) begin
      fails++; $display("FAIL regrant_first: we %b addr %h data %h busy %b want 1/040/444/100",
                        bus.ram_we, bus.ram_addr, bus.ram_data, bus.busy);
    end
    repeat (6) step();                          // 10
    tests++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 11'h041 || bus.ram_data !== 12'h555 ||
                 bus.grant_id !== 3'd2 || bus.ovf !== 3'b000) begin
      fails++; $display("FAIL regrant_second: we %b addr %h data %h gid %0d ovf %b want 1/041/555/2/000",
                        bus.ram_we, bus.ram_addr, bus.ram_data, bus.grant_id, bus.ovf);
    end
  endtask

  task automatic test_fairness();
    int   n = 0;
    logic prev = 1'b0;
    apply_reset();
    drive(0, 11'h001, 12'h00A);
    drive(1, 11'h002, 12'h00B);
    drive(2, 11'h003, 12'h00C);
    for (int c = 0; c < 400 && n < 30; c++) begin
      step();
      if (bus.ram_we && !prev) begin
        tests++;
        if (bus.grant_id !== 3'(n % 3)) begin
          fails++; $display("FAIL fair_grant #%0d: got %0d want %0d", n, bus.grant_id, n % 3);
        end
        n++;
      end
      prev = bus.ram_we;
    end
    clear_req();
    tests++; if (n != 30) begin fails++; $display("FAIL fair_count: got %0d writes want 30", n); end
  endtask

  task automatic test_reset_midwrite();
    apply_reset();
    drive(0, 11'h007, 12'h070);
    drive(1, 11'h008, 12'h080);
    step(); clear_req();                        // 1
    step();                                     // 2: WE cycle 1
    step();                                     // 3: WE cycle 2
    rst = 1'b1;
    #1;
    tests++; if (bus.ram_we !== 1'b0 || bus.busy !== 3'b000) begin
      fails++; $display("FAIL rst_mid: we %b busy %b want 0/000", bus.ram_we, bus.busy);
    end
    step(); rst = 1'b0;                         // 4
    drive(1, 11'h009, 12'h999);
    step(); clear_req();                        // 5
    tests++; if (bus.busy !== 3'b010) begin fails++; $display("FAIL rst_after_busy: got %b want 010", bus.busy); end
    step();                                     // 6
    tests++; if (bus.ram_we !== 1'b1 || bus.grant_id !== 3'd1 || bus.ram_addr !== 11'h009 || bus.ram_data !== 12'h999) begin
      fails++; $display("FAIL rst_after_write: we %b gid %0d addr %h data %h want 1/1/009/999",
                        bus.ram_we, bus.grant_id, bus.ram_addr, bus.ram_data);
    end
  endtask

  initial begin
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0; bus.clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_all_three();
    test_overflow();
    test_addr0_regrant();
    test_fairness();
    test_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
